// File: rtl/spi_cs_scheduler_pkg.sv
// rtl/spi_cs_scheduler_pkg.sv - shared types and helpers for the SPI chip-select scheduler
package spi_cs_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WAIT_RX,
    ST_GAP
  } state_t;

  // Index widths never collapse to zero, even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_cs_scheduler_rr_arbiter.sv
// rtl/spi_cs_scheduler_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module spi_cs_scheduler_rr_arbiter
  import spi_cs_scheduler_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    // Walk the ring once; the previous winner is visited last.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = IDW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cs_scheduler.sv
// rtl/spi_cs_scheduler.sv - shares one byte SPI engine between requesters with per-requester CS
module spi_cs_scheduler
  import spi_cs_scheduler_pkg::*;
#(
  parameter int N_REQ            = 2,
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1,
  parameter int CS_SETUP_CLKS    = 1,
  parameter int HOLD_TIMEOUT     = 16,
  localparam int IDW             = clog2_min1(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [7:0]         rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               eng_tx_valid,
  output logic [7:0]         eng_tx_data,
  input  logic               eng_tx_ready,
  input  logic               eng_rx_valid,
  input  logic [7:0]         eng_rx_data,
  output logic [N_REQ-1:0]   cs_n,
  output logic               busy
);

  localparam int BCW = clog2_min1(MAX_BYTES_PER_CS + 1);
  localparam int TW  = 16;

  state_t            state_q, state_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic              last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic [N_REQ-1:0]  arb_oh;
  logic [IDW-1:0]    arb_idx;
  logic              arb_any;
  logic              sel_valid;
  logic [7:0]        sel_data;
  logic              cs_active;

  spi_cs_scheduler_rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_onehot (arb_oh),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  assign sel_valid = req_valid[grant_q];
  assign sel_data  = req_data[8*int'(grant_q) +: 8];
  // CS is decoded from flopped state so an async reset drops it with no edge.
  assign cs_active = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_WAIT_RX);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    last_d       = last_q;
    timer_d      = timer_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    req_ready    = '0;
    eng_tx_valid = 1'b0;
    eng_tx_data  = 8'h00;
    cs_n         = cs_active ? ~grant_oh_q : '1;

    case (state_q)
      ST_IDLE: begin
        if (enable && arb_any) begin
          grant_d      = arb_idx;
          grant_oh_d   = arb_oh;
          last_grant_d = arb_idx;
          timer_d      = '0;
          state_d      = (CS_SETUP_CLKS == 0) ? ST_XFER : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (int'(timer_q) >= CS_SETUP_CLKS - 1) begin
          timer_d = '0;
          state_d = ST_XFER;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_XFER: begin
        eng_tx_valid = sel_valid;
        eng_tx_data  = sel_data;
        req_ready    = grant_oh_q & {N_REQ{eng_tx_ready}};
        if (sel_valid) begin
          timer_d = '0;
          if (eng_tx_ready) begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
            last_d     = req_last[grant_q];
            state_d    = ST_WAIT_RX;
          end
        end else if (int'(timer_q) >= HOLD_TIMEOUT - 1) begin
          timer_d = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_RX: begin
        if (eng_rx_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = eng_rx_data;
          rsp_id_d    = grant_q;
          timer_d     = '0;
          state_d     = (last_q || int'(byte_cnt_q) >= MAX_BYTES_PER_CS) ? ST_GAP : ST_XFER;
        end
      end
      ST_GAP: begin
        byte_cnt_d = '0;
        last_d     = 1'b0;
        if (int'(timer_q) >= CS_INACTIVE_CLKS - 1) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDW'(N_REQ - 1);
      byte_cnt_q   <= '0;
      last_q       <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cs_scheduler.sv
// tb/tb_spi_cs_scheduler.sv - directed bench for spi_cs_scheduler with loopback engine
module tb_spi_cs_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_id;
  logic        eng_tx_valid;
  logic [7:0]  eng_tx_data;
  logic        eng_tx_ready = 1'b1;
  logic        eng_rx_valid = 1'b0;
  logic [7:0]  eng_rx_data = 8'h00;
  logic [1:0]  cs_n;
  logic        busy;

  spi_cs_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .eng_tx_valid (eng_tx_valid),
    .eng_tx_data  (eng_tx_data),
    .eng_tx_ready (eng_tx_ready),
    .eng_rx_valid (eng_rx_valid),
    .eng_rx_data  (eng_rx_data),
    .cs_n         (cs_n),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         owner_log[$];
  int         bytes_log[$];
  int         gap_log[$];
  int         tail_log[$];
  logic [8:0] rsp_log[$];
  int         pend = 0;
  logic [7:0] pend_byte = 8'h00;
  int         bad_cs = 0;
  int         ready_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester queues, loopback engine (2-cycle latency) and CS window monitor.
  initial begin
    logic [1:0] acc;
    logic       tx_acc;
    logic [7:0] tx_byte;
    logic       asserted;
    logic       was_asserted;
    int         high_run;
    int         cur_bytes;
    int         tail;
    bit         seen;
    was_asserted = 1'b0;
    high_run = 0;
    cur_bytes = 0;
    tail = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      acc      = req_valid & req_ready;
      tx_acc   = eng_tx_valid && eng_tx_ready;
      tx_byte  = eng_tx_data;
      asserted = (cs_n != 2'b11);
      if (cs_n == 2'b00) bad_cs++;
      if ((req_ready & cs_n) != 2'b00) ready_viol++;
      if (asserted && !was_asserted) begin
        owner_log.push_back((cs_n == 2'b10) ? 0 : 1);
        if (seen) gap_log.push_back(high_run);
        seen = 1'b1;
        cur_bytes = 0;
        tail = 0;
      end
      if (!asserted && was_asserted) begin
        bytes_log.push_back(cur_bytes);
        tail_log.push_back(tail);
      end
      if (asserted) begin
        high_run = 0;
        if (tx_acc) cur_bytes++;
      end else begin
        high_run++;
      end
      if (rsp_valid) begin
        rsp_log.push_back({rsp_id, rsp_data});
        tail = asserted ? 1 : 0;
      end else if (asserted) begin
        tail++;
      end
      was_asserted = asserted;

      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0] = (q0.size() > 0);
      {req_last[0], req_data[7:0]} = (q0.size() > 0) ? q0[0] : 9'h000;
      req_valid[1] = (q1.size() > 0);
      {req_last[1], req_data[15:8]} = (q1.size() > 0) ? q1[0] : 9'h000;
      eng_rx_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          eng_rx_valid = 1'b1;
          eng_rx_data  = pend_byte;
        end
      end
      if (tx_acc) begin
        pend = 2;
        pend_byte = tx_byte;
      end
    end
  end

  task automatic wait_done(input string tag, input int budget);
    int cnt;
    int stable;
    cnt = 0;
    stable = 0;
    while (stable < 3 && cnt < budget) begin
      @(negedge clk);
      cnt++;
      if (!busy && q0.size() == 0 && q1.size() == 0 && pend == 0 && !eng_rx_valid) stable++;
      else stable = 0;
    end
    check({tag, "_done"}, (stable >= 3) ? 1 : 0, 1);
  endtask

  initial begin
    int bo;
    int br;
    int n;
    int exp_b[3];
    exp_b = '{2, 2, 1};

    #1 rst = 1'b0;
    #1;
    check("rst_cs_n", cs_n, 2'b11);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_tx_valid", eng_tx_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    enable = 1'b1;

    // single byte, last set
    bo = owner_log.size(); br = rsp_log.size();
    q0.push_back({1'b1, 8'hA5});
    wait_done("t1", 200);
    check("t1_nassert", owner_log.size() - bo, 1);
    check("t1_owner", owner_log[bo], 0);
    check("t1_bytes", bytes_log[bo], 1);
    check("t1_nrsp", rsp_log.size() - br, 1);
    check("t1_rsp", rsp_log[br], {1'b0, 8'hA5});
    check("t1_busy", busy, 0);
    check("t1_cs_n", cs_n, 2'b11);

    // five bytes split 2,2,1 by the per-CS limit
    bo = owner_log.size(); br = rsp_log.size();
    for (int m = 0; m < 5; m++) q0.push_back({(m == 4) ? 1'b1 : 1'b0, 8'(8'h11 * (m + 1))});
    wait_done("t2", 400);
    check("t2_nassert", owner_log.size() - bo, 3);
    for (int k = 0; k < 3; k++) begin
      check("t2_owner", owner_log[bo + k], 0);
      check("t2_bytes", bytes_log[bo + k], exp_b[k]);
      check("t2_gap", (gap_log[bo + k - 1] >= 2) ? 1 : 0, 1);
    end
    check("t2_nrsp", rsp_log.size() - br, 5);
    for (int m = 0; m < 5; m++) check("t2_rsp", rsp_log[br + m], {1'b0, 8'(8'h11 * (m + 1))});

    // requester 1 stalls after a non-last byte
    bo = owner_log.size(); br = rsp_log.size();
    q1.push_back({1'b0, 8'h3C});
    wait_done("t4", 400);
    check("t4_nassert", owner_log.size() - bo, 1);
    check("t4_owner", owner_log[bo], 1);
    check("t4_bytes", bytes_log[bo], 1);
    check("t4_hold", tail_log[bo], 16);
    check("t4_nrsp", rsp_log.size() - br, 1);
    check("t4_rsp", rsp_log[br], {1'b1, 8'h3C});

    // both requesters stream two 4-byte frames; grants alternate
    bo = owner_log.size(); br = rsp_log.size();
    for (int m = 0; m < 8; m++) begin
      q0.push_back({((m % 4) == 3) ? 1'b1 : 1'b0, 8'(8'hA0 + m)});
      q1.push_back({((m % 4) == 3) ? 1'b1 : 1'b0, 8'(8'hB0 + m)});
    end
    wait_done("t3", 1000);
    check("t3_nassert", owner_log.size() - bo, 8);
    for (int k = 0; k < 8; k++) begin
      check("t3_owner", owner_log[bo + k], k % 2);
      check("t3_bytes", bytes_log[bo + k], 2);
      for (int j = 0; j < 2; j++)
        check("t3_rsp", rsp_log[br + 2 * k + j],
              {1'(k % 2), 8'((((k % 2) != 0) ? 8'hB0 : 8'hA0) + 2 * (k / 2) + j)});
    end
    check("t3_ready_viol", ready_viol, 0);

    // enable low blocks new grants
    bo = owner_log.size();
    enable = 1'b0;
    q0.push_back({1'b1, 8'hC0});
    q1.push_back({1'b1, 8'hD0});
    repeat (10) @(negedge clk);
    check("t6_busy_off", busy, 0);
    check("t6_cs_off", cs_n, 2'b11);
    check("t6_nassert_off", owner_log.size() - bo, 0);
    enable = 1'b1;
    wait_done("t6a", 300);
    check("t6_nassert_on", owner_log.size() - bo, 2);
    check("t6_owner0", owner_log[bo], 0);
    check("t6_owner1", owner_log[bo + 1], 1);

    // enable dropped mid-frame; frame still completes
    bo = owner_log.size();
    q0.push_back({1'b0, 8'hE0});
    q0.push_back({1'b1, 8'hE1});
    n = 0;
    do begin @(negedge clk); n++; end while (cs_n == 2'b11 && n < 50);
    check("t6_cs_seen", (n < 50) ? 1 : 0, 1);
    enable = 1'b0;
    wait_done("t6b", 300);
    check("t6_mid_nassert", owner_log.size() - bo, 1);
    check("t6_mid_bytes", bytes_log[bo], 2);
    check("t6_mid_busy", busy, 0);
    enable = 1'b1;

    // async reset while waiting for the received byte
    q0.push_back({1'b1, 8'hF0});
    n = 0;
    do begin @(negedge clk); n++; end while (!(eng_tx_valid && eng_tx_ready) && n < 50);
    check("t5_tx_seen", (n < 50) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_cs_n", cs_n, 2'b11);
    check("t5_tx_valid", eng_tx_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_req_ready", req_ready, 2'b00);
    q0.delete();
    q1.delete();
    bo = owner_log.size(); br = rsp_log.size();
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    q0.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h62});
    wait_done("t5", 300);
    check("t5_nassert", owner_log.size() - bo, 2);
    check("t5_owner0", owner_log[bo], 0);
    check("t5_owner1", owner_log[bo + 1], 1);
    check("t5_nrsp", rsp_log.size() - br, 2);
    check("t5_rsp0", rsp_log[br], {1'b0, 8'h61});
    check("t5_rsp1", rsp_log[br + 1], {1'b1, 8'h62});

    check("cs_onehot", bad_cs, 0);
    check("ready_viol", ready_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
